d2f: RTL and testbench
======================

Name: d2f

Overview:
- Converts an IEEE-754 binary64 operand to binary32: narrowing conversion with full rounding and exception flags.
- Pipelined companion to the single-to-double widening converter; sits in the FPU conversion lane alongside it.
- Two register stages with valid/ready handshakes on both sides; throughput one conversion per cycle.

Parameters:
- None. Source and destination formats are fixed (FP64 in, FP32 out).

Ports:
- clk_i  input  1  clock, all state on rising edge
- reset_i  input  1  asynchronous, active-high reset
- flush_i  input  1  synchronous pipeline clear
- valid_i  input  1  operand valid
- ready_o  output  1  block can accept operand
- a_i  input  64  binary64 operand
- rm_i  input  3  rounding mode (roundmode_e)
- valid_o  output  1  result valid
- ready_i  input  1  downstream accepts result
- rnd_result_o  output  37  Structs#(FP32)::round_res_t: result[31:0] plus status_t flags {NV,DZ,OF,UF,NX}

Behaviour:
- Reset: both stage valid bits 0. valid_o=0, rnd_result_o=0. ready_o=1 once reset deasserts.
- Handshake:
  - Input transfer on valid_i&&ready_o. Output transfer on valid_o&&ready_i.
  - Stage advances when its successor is empty or advancing. ready_o = !s1_valid || s1_advance.
  - Latency 2 cycles from transfer to valid_o with no stall.
  - rnd_result_o is held stable while valid_o&&!ready_i. No loss, no duplication, order preserved.
- flush_i: clears both valid bits next edge. Takes precedence over a simultaneous input transfer, which is dropped.
- Stage 1 (classify/align), registers sign, class, exp32 candidate, 24-bit significand, round bit, sticky, rm:
  - exp32 = exp64 - 896, computed 12-bit signed.
  - Normal range 1..254: significand {1,mant[51:29]}, round=mant[28], sticky=|mant[27:0].
  - exp32 <= 0: significand right-shifted by 1-exp32, shift capped at 26; shifted-out bits feed round/sticky; exp32 forced 0.
  - binary64 subnormal input: treated as tiny, significand 0, sticky=1.
- Stage 2 (round/pack):
  - Increment rule:
    - RNE: round&&(sticky||lsb)
    - RTZ: never
    - RDN: sign&&(round||sticky)
    - RUP: !sign&&(round||sticky)
    - RMM: round
    - rm values 101..111: treated as RNE.
  - Add is done on {exp,mant}, so mantissa carry propagates into exponent (subnormal->min normal, 254->255).
  - Overflow: pre-round exp32 >= 255, or post-round exp == 255 → OF|NX. Result:
    - RNE/RMM: ±inf
    - RTZ: ±0x7F7FFFFF
    - RDN: +max / -inf
    - RUP: +inf / -max
  - NX = round||sticky. UF = tiny-before-rounding (pre-round exp32 <= 0) && NX.
- Specials:
  - ±zero → ±0, no flags.
  - ±inf → ±inf, no flags.
  - NaN → {sign, 8'hFF, 1'b1, mant[50:29]}. NV only for sNaN.
- DZ is always 0.
- reset_i mid-stall: outputs return to reset values immediately; in-flight data is discarded.

Optional Feature:
- FP_D2F_CANONICAL_NAN_EN defined: every NaN output is 0x7FC00000 (sign and payload dropped); NV rule is unchanged.
- Undefined: payload/sign propagation as in Behaviour.

Decomposition:
- fp_pkg:
  - roundmode_e {RNE=3'b000, RTZ=3'b001, RDN=3'b010, RUP=3'b011, RMM=3'b100}
  - localparams FP32_BIAS=127, FP64_BIAS=1023, D2F_EXP_OFFSET=896
  - reuse status_t, fp_info_t, Structs/Functions#(FP_FORMAT).
- One sub-module d2f_rnd: combinational increment decision from {sign, lsb, round, sticky, rm}. Shared later by other narrowing converters.

Test Plan:
- Simple and tie rounding:
  - a=0x3FF0000000000000, RNE → 0x3F800000, flags 0, valid_o exactly 2 cycles after transfer.
  - a=0x3FF0000010000000: RNE → 0x3F800000 NX; RUP → 0x3F800001 NX; RMM → 0x3F800001 NX.
- Overflow: a=0x47F0000000000000: RNE → 0x7F800000 OF|NX; RTZ → 0x7F7FFFFF OF|NX; a=0xC7F0000000000000 with RUP → 0xFF7FFFFF OF|NX.
- Tiny/subnormal:
  - a=0x36A0000000000000 → 0x00000001, flags 0.
  - a=0x0000000000000001: RUP → 0x00000001 UF|NX; RNE → 0x00000000 UF|NX.
- NaN:
  - a=0x7FF4000000000000 → 0x7FE00000 NV (0x7FC00000 NV with FP_D2F_CANONICAL_NAN_EN).
  - a=0xFFF8000000000000 → 0xFFC00000, flags 0.
- Handshake and reset: 3 back-to-back ops, ready_i=0 from the first valid_o:
  - ready_o drops once both stages are full; rnd_result_o stable while stalled.
  - Releasing ready_i yields all 3 results in order.
  - flush_i or reset_i asserted during the stall → valid_o=0 next edge (reset: immediately).

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point types for the FPU conversion lane.
// Provides the rounding-mode encoding, the IEEE status flags, the rounded-result
// bus payload, the stage-1 payload of the binary64->binary32 narrowing converter,
// and a helper that selects the overflow result for a rounding mode.
package fp_pkg;

  localparam int unsigned FP32_BIAS      = 127;
  localparam int unsigned FP64_BIAS      = 1023;
  localparam int unsigned D2F_EXP_OFFSET = FP64_BIAS - FP32_BIAS;

  localparam int unsigned FP32_W        = 32;
  localparam int unsigned FP64_W        = 64;
  localparam int unsigned FP32_MAN_W    = 23;
  localparam int unsigned FP64_MAN_W    = 52;
  localparam int unsigned FP64_EXP_W    = 11;
  localparam int unsigned D2F_EXP_W     = 12;
  localparam int unsigned D2F_SIG_W     = FP32_MAN_W + 1;
  localparam int unsigned D2F_SHIFT_CAP = 26;
  localparam int unsigned RM_W          = 3;

  typedef enum logic [RM_W-1:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef struct packed {
    logic [FP32_W-1:0] result;
    status_t           status;
  } round_res_t;

  typedef enum logic [2:0] {
    CLS_FINITE,
    CLS_ZERO,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  // Stage-1 payload; for NaNs the sig field carries the 22-bit payload.
  typedef struct packed {
    logic                 sign;
    fp_class_e            cls;
    logic [D2F_EXP_W-1:0] exp;
    logic [D2F_SIG_W-1:0] sig;
    logic                 round;
    logic                 sticky;
    logic [RM_W-1:0]      rm;
  } d2f_s1_t;

  // Result of an overflowing binary32 operation under rounding mode rm.
  function automatic logic [FP32_W-1:0] fp32_ovf_result(input logic sign,
                                                         input logic [RM_W-1:0] rm);
    logic [FP32_W-1:0] inf_v;
    logic [FP32_W-1:0] max_v;
    inf_v = {sign, 31'h7F800000};
    max_v = {sign, 31'h7F7FFFFF};
    case (rm)
      RTZ:     return max_v;
      RDN:     return sign ? inf_v : max_v;
      RUP:     return sign ? max_v : inf_v;
      default: return inf_v;
    endcase
  endfunction

endpackage

// File: rtl/d2f_rnd.sv
// Rounding-increment decision for narrowing converters.
// Ports: sign, lsb, round, sticky of the truncated significand; rm rounding
// mode (encodings above RMM behave as RNE); inc_c = add one ulp.
module d2f_rnd
  import fp_pkg::*;
(
  input  logic            sign,
  input  logic            lsb,
  input  logic            round,
  input  logic            sticky,
  input  logic [RM_W-1:0] rm,
  output logic            inc_c
);

  always_comb begin
    inc_c = 1'b0;
    case (rm)
      RTZ:     inc_c = 1'b0;
      RDN:     inc_c = sign & (round | sticky);
      RUP:     inc_c = ~sign & (round | sticky);
      RMM:     inc_c = round;
      default: inc_c = round & (sticky | lsb);
    endcase
  end

endmodule

// File: rtl/d2f.sv
// Pipelined binary64 -> binary32 narrowing converter with full rounding and
// IEEE exception flags. Two register stages (classify/align, round/pack) with
// valid/ready handshakes on both sides; one conversion per cycle.
// Ports: clk_i, reset_i (async, active high), flush_i (sync clear),
//   valid_i/ready_o/a_i/rm_i operand side, valid_o/ready_i/rnd_result_o result
//   side (rnd_result_o = {result[31:0], NV, DZ, OF, UF, NX}).
// Build option: FP_D2F_CANONICAL_NAN_EN makes every NaN result 0x7FC00000.
module d2f
  import fp_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [FP64_W-1:0]     a_i,
  input  logic [RM_W-1:0]       rm_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output round_res_t            rnd_result_o
);

  localparam int unsigned WIDE_W = 1 + FP64_MAN_W + D2F_SHIFT_CAP;

  logic [FP64_EXP_W-1:0]       exp64;
  logic [FP64_MAN_W-1:0]       mant;
  logic signed [D2F_EXP_W-1:0] exp32;
  logic signed [D2F_EXP_W-1:0] sh_full;
  logic [4:0]                  sh;
  logic [WIDE_W-1:0]           wide;
  logic [WIDE_W-1:0]           shifted;
  d2f_s1_t                     s1_next;
  d2f_s1_t                     s1_q;
  logic                        s1_valid;
  logic                        s1_advance;
  logic                        s2_ready;
  logic                        in_fire;

  logic signed [D2F_EXP_W-1:0] exp_pre;
  logic                        tiny;
  logic                        inexact;
  logic                        inc_c;
  logic [FP32_W-2:0]           mag;
  logic [FP32_W-2:0]           rounded;
  round_res_t                  res_next;

  // Handshake: a stage advances when its successor is empty or advancing.
  assign s2_ready   = ~valid_o | ready_i;
  assign s1_advance = s1_valid & s2_ready;
  assign ready_o    = ~s1_valid | s1_advance;
  assign in_fire    = valid_i & ready_o;

  // Stage 1: rebias exponent and align tiny values into the subnormal grid.
  assign exp64   = a_i[62:52];
  assign mant    = a_i[FP64_MAN_W-1:0];
  assign exp32   = $signed({1'b0, exp64}) - $signed(12'(D2F_EXP_OFFSET));
  assign sh_full = 12'sd1 - exp32;
  assign sh      = (sh_full > $signed(12'(D2F_SHIFT_CAP))) ? 5'(D2F_SHIFT_CAP) : 5'(sh_full);
  assign wide    = {1'b1, mant, 26'b0};
  assign shifted = wide >> ((exp32 <= 12'sd0) ? sh : 5'd0);

  always_comb begin
    s1_next      = '0;
    s1_next.sign = a_i[63];
    s1_next.rm   = rm_i;
    if (exp64 == '1) begin
      s1_next.sig = {2'b00, mant[50:29]};
      if (mant == '0)   s1_next.cls = CLS_INF;
      else if (mant[51]) s1_next.cls = CLS_QNAN;
      else              s1_next.cls = CLS_SNAN;
    end else if (exp64 == '0) begin
      // binary64 subnormals are far below binary32 range: only sticky survives
      if (mant == '0) begin
        s1_next.cls = CLS_ZERO;
      end else begin
        s1_next.cls    = CLS_FINITE;
        s1_next.sticky = 1'b1;
      end
    end else begin
      s1_next.cls    = CLS_FINITE;
      s1_next.exp    = (exp32 <= 12'sd0) ? 12'd0 : $unsigned(exp32);
      s1_next.sig    = shifted[78:55];
      s1_next.round  = shifted[54];
      s1_next.sticky = |shifted[53:0];
    end
  end

  // Stage 2: round on {exp, mant} so a mantissa carry bumps the exponent.
  assign exp_pre = $signed(s1_q.exp);
  assign tiny    = (exp_pre == 12'sd0);
  assign inexact = s1_q.round | s1_q.sticky;
  // tiny operands have no hidden bit; exponent field comes from sig[23] (always 0)
  assign mag     = {tiny ? {7'b0, s1_q.sig[23]} : s1_q.exp[7:0], s1_q.sig[22:0]};
  assign rounded = mag + {30'b0, inc_c};

  d2f_rnd u_rnd (
    .sign   (s1_q.sign),
    .lsb    (s1_q.sig[0]),
    .round  (s1_q.round),
    .sticky (s1_q.sticky),
    .rm     (s1_q.rm),
    .inc_c  (inc_c)
  );

  always_comb begin
    res_next = '0;
    case (s1_q.cls)
      CLS_ZERO: res_next.result = {s1_q.sign, 31'b0};
      CLS_INF:  res_next.result = {s1_q.sign, 8'hFF, 23'b0};
      CLS_QNAN, CLS_SNAN: begin
`ifdef FP_D2F_CANONICAL_NAN_EN
        res_next.result = 32'h7FC00000;
`else
        res_next.result = {s1_q.sign, 8'hFF, 1'b1, s1_q.sig[21:0]};
`endif
        res_next.status.nv = (s1_q.cls == CLS_SNAN);
      end
      default: begin
        if (exp_pre >= 12'sd255 || rounded[30:23] == 8'hFF) begin
          res_next.result    = fp32_ovf_result(s1_q.sign, s1_q.rm);
          res_next.status.of = 1'b1;
          res_next.status.nx = 1'b1;
        end else begin
          res_next.result    = {s1_q.sign, rounded};
          res_next.status.nx = inexact;
          res_next.status.uf = tiny & inexact;
        end
      end
    endcase
  end

  // Pipeline registers; flush clears only the valid bits.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid     <= 1'b0;
      valid_o      <= 1'b0;
      s1_q         <= '0;
      rnd_result_o <= '0;
    end else begin
      if (flush_i) begin
        s1_valid <= 1'b0;
        valid_o  <= 1'b0;
      end else begin
        if (ready_o)  s1_valid <= valid_i;
        if (s2_ready) valid_o  <= s1_valid;
      end
      if (in_fire)    s1_q         <= s1_next;
      if (s1_advance) rnd_result_o <= res_next;
    end
  end

endmodule

// File: tb/tb_d2f.sv
// Self-checking bench for d2f: directed vectors with known answers, handshake
// stall/flush/reset scenarios, and randomized traffic against a value-level
// reference model (exact integer scaling, no fixed shift window).
module tb_d2f;

  logic        clk = 1'b0;
  logic        reset_i, flush_i, valid_i, ready_o, valid_o, ready_i;
  logic [63:0] a_i;
  logic [2:0]  rm_i;
  logic [36:0] rnd_result_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [36:0] v;
    string       tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [63:0] a;
    logic [2:0]  rm;
    logic [36:0] e;
  } vec_t;
  vec_t dir[$];

  d2f dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .a_i          (a_i),
    .rm_i         (rm_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .rnd_result_o (rnd_result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference: value = m * 2^E; quantize to the binary32 grid of its binade.
  function automatic logic [36:0] model(input logic [63:0] a, input logic [2:0] rm);
    logic              s, half, stk, inc, tiny;
    int                e, top, sh, q;
    longint unsigned   f, m, n, bits;
    logic [31:0]       r;
    logic [4:0]        fl;
    s  = a[63];
    e  = int'(a[62:52]);
    f  = {12'b0, a[51:0]};
    fl = 5'b0;
    if (e == 2047) begin
      if (f == 0) begin
        r = {s, 31'h7F800000};
      end else begin
`ifdef FP_D2F_CANONICAL_NAN_EN
        r = 32'h7FC00000;
`else
        r = {s, 8'hFF, 1'b1, a[50:29]};
`endif
        if (!a[51]) fl[4] = 1'b1;
      end
      return {r, fl};
    end
    if (e == 0 && f == 0) return {s, 31'b0, 5'b0};
    if (e == 0) begin
      m = f; top = -1023; sh = 925;
    end else begin
      m   = f | (64'd1 << 52);
      top = e - 1023;
      sh  = (top >= -126) ? 29 : 926 - e;
    end
    tiny = (top < -126);
    n    = (sh >= 64) ? 64'd0 : (m >> sh);
    half = (sh - 1 >= 64) ? 1'b0 : (((m >> (sh - 1)) & 64'd1) != 0);
    stk  = (sh - 1 >= 64) ? (m != 0) : ((m & ((64'd1 << (sh - 1)) - 64'd1)) != 0);
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s && (half || stk);
      3'd3:    inc = !s && (half || stk);
      3'd4:    inc = half;
      default: inc = half && (stk || n[0]);
    endcase
    n    = n + 64'(inc);
    q    = tiny ? -149 : top - 23;
    bits = (64'(q + 149) << 23) + n;
    if (bits >= 64'h7F800000) begin
      case (rm)
        3'd1:    r = {s, 31'h7F7FFFFF};
        3'd2:    r = s ? 32'hFF800000 : 32'h7F7FFFFF;
        3'd3:    r = s ? 32'hFF7FFFFF : 32'h7F800000;
        default: r = {s, 31'h7F800000};
      endcase
      return {r, 5'b00101};
    end
    r     = {s, bits[30:0]};
    fl[0] = half | stk;
    fl[1] = tiny & fl[0];
    return {r, fl};
  endfunction

  function automatic logic [63:0] rand_a();
    logic [63:0] a;
    int          k, ex;
    a  = {$urandom, $urandom};
    k  = $urandom_range(0, 9);
    ex = int'(a[62:52]);
    case (k)
      0, 1, 2, 3: ex = $urandom_range(883, 1153);
      4:          ex = $urandom_range(850, 900);
      5:          ex = $urandom_range(1140, 1160);
      6: begin ex = 0;    if ($urandom_range(0, 1) == 0) a[51:0] = '0; end
      7: begin ex = 2047; if ($urandom_range(0, 2) == 0) a[51:0] = '0; end
      8: begin ex = $urandom_range(860, 1160); a[27:0] = '0; end
      default: ;
    endcase
    a[62:52] = 11'(ex);
    return a;
  endfunction

  task automatic add_dir(input logic [63:0] a, input logic [2:0] rm,
                         input logic [31:0] r, input logic [4:0] fl);
    vec_t v;
    v.a = a; v.rm = rm; v.e = {r, fl};
    dir.push_back(v);
  endtask

  // One cycle: drive, settle, score transfers at negedge, return at posedge+1.
  task automatic step(input logic v, input logic [63:0] a, input logic [2:0] rm,
                      input logic rdy, input logic [36:0] expv, input string tag);
    exp_t e;
    a_i = a; rm_i = rm; valid_i = v; ready_i = rdy;
    @(negedge clk);
    if (valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(valid_o), 64'd0);
      end else begin
        e = sb.pop_front();
        check(e.tag, 64'(rnd_result_o), 64'(e.v));
      end
    end
    if (valid_i && ready_o && !flush_i) begin
      e.v = expv; e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 50) begin
      step(1'b0, 64'd0, 3'd0, 1'b1, 37'd0, "");
      g++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic stall_cycles(input int n, input logic v, input logic [63:0] a);
    for (int k = 0; k < n; k++) begin
      valid_i = v; a_i = a; ready_i = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; rm_i = '0;

    add_dir(64'h3FF0000000000000, 3'd0, 32'h3F800000, 5'h00);
    add_dir(64'h3FF0000010000000, 3'd0, 32'h3F800000, 5'h01);
    add_dir(64'h3FF0000010000000, 3'd3, 32'h3F800001, 5'h01);
    add_dir(64'h3FF0000010000000, 3'd4, 32'h3F800001, 5'h01);
    add_dir(64'h47F0000000000000, 3'd0, 32'h7F800000, 5'h05);
    add_dir(64'h47F0000000000000, 3'd1, 32'h7F7FFFFF, 5'h05);
    add_dir(64'hC7F0000000000000, 3'd3, 32'hFF7FFFFF, 5'h05);
    add_dir(64'h36A0000000000000, 3'd0, 32'h00000001, 5'h00);
    add_dir(64'h0000000000000001, 3'd3, 32'h00000001, 5'h03);
    add_dir(64'h0000000000000001, 3'd0, 32'h00000000, 5'h03);
`ifdef FP_D2F_CANONICAL_NAN_EN
    add_dir(64'h7FF4000000000000, 3'd0, 32'h7FC00000, 5'h10);
    add_dir(64'hFFF8000000000000, 3'd0, 32'h7FC00000, 5'h00);
`else
    add_dir(64'h7FF4000000000000, 3'd0, 32'h7FE00000, 5'h10);
    add_dir(64'hFFF8000000000000, 3'd0, 32'hFFC00000, 5'h00);
`endif
    add_dir(64'h8000000000000000, 3'd0, 32'h80000000, 5'h00);
    add_dir(64'hFFF0000000000000, 3'd2, 32'hFF800000, 5'h00);
    add_dir(64'h3FF0000030000000, 3'd0, 32'h3F800002, 5'h01);
    add_dir(64'h3FF0000010000000, 3'd5, 32'h3F800000, 5'h01);
    add_dir(64'h47EFFFFFF0000000, 3'd0, 32'h7F800000, 5'h05);
    add_dir(64'h380FFFFFF0000000, 3'd0, 32'h00800000, 5'h03);
    add_dir(64'hC7F0000000000000, 3'd2, 32'hFF800000, 5'h05);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_result", 64'(rnd_result_o), 64'd0);
    reset_i = 1'b0;
    #1;
    check("rst_ready_o", 64'(ready_o), 64'd1);

    // latency of the first transaction
    step(1'b1, dir[0].a, dir[0].rm, 1'b1, dir[0].e, "dir0");
    check("lat_c1_valid_o", 64'(valid_o), 64'd0);
    step(1'b0, 64'd0, 3'd0, 1'b1, 37'd0, "");
    check("lat_c2_valid_o", 64'(valid_o), 64'd1);

    // remaining directed vectors back to back
    for (int i = 1; i < dir.size(); i++)
      step(1'b1, dir[i].a, dir[i].rm, 1'b1, dir[i].e, $sformatf("dir%0d", i));
    drain();

    // stall: A, B in flight, C waiting, downstream not ready
    step(1'b1, dir[0].a, dir[0].rm, 1'b1, dir[0].e, "stall_A");
    step(1'b1, dir[4].a, dir[4].rm, 1'b1, dir[4].e, "stall_B");
    for (int k = 0; k < 4; k++) begin
      a_i = dir[10].a; rm_i = dir[10].rm; valid_i = 1'b1; ready_i = 1'b0;
      @(negedge clk);
      check("stall_ready_o", 64'(ready_o), 64'd0);
      check("stall_valid_o", 64'(valid_o), 64'd1);
      check("stall_hold", 64'(rnd_result_o), 64'(dir[0].e));
      @(posedge clk);
      #1;
    end
    step(1'b1, dir[10].a, dir[10].rm, 1'b1, dir[10].e, "stall_C");
    drain();

    // flush during a stall drops everything, including the coincident input
    step(1'b1, dir[1].a, dir[1].rm, 1'b1, dir[1].e, "fl_A");
    step(1'b1, dir[2].a, dir[2].rm, 1'b1, dir[2].e, "fl_B");
    stall_cycles(2, 1'b0, 64'd0);
    flush_i = 1'b1; valid_i = 1'b1; a_i = dir[3].a; ready_i = 1'b0;
    @(posedge clk);
    #1;
    flush_i = 1'b0; valid_i = 1'b0;
    check("flush_valid_o", 64'(valid_o), 64'd0);
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 64'd0, 3'd0, 1'b1, 37'd0, "");
      check("flush_drop", 64'(valid_o), 64'd0);
    end

    // reset during a stall clears outputs immediately
    step(1'b1, dir[5].a, dir[5].rm, 1'b1, dir[5].e, "rs_A");
    step(1'b1, dir[6].a, dir[6].rm, 1'b1, dir[6].e, "rs_B");
    stall_cycles(2, 1'b0, 64'd0);
    #2;
    reset_i = 1'b1;
    #1;
    check("rst_mid_valid_o", 64'(valid_o), 64'd0);
    check("rst_mid_result", 64'(rnd_result_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_ready_o", 64'(ready_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 64'd0, 3'd0, 1'b1, 37'd0, "");
      check("rst_mid_idle", 64'(valid_o), 64'd0);
    end
    step(1'b1, dir[7].a, dir[7].rm, 1'b1, dir[7].e, "post_rst");
    drain();

    // randomized traffic with random back-pressure
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] a;
      logic [2:0]  rm;
      logic        v, rdy;
      a   = rand_a();
      rm  = 3'($urandom_range(0, 7));
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      step(v, a, rm, rdy, model(a, rm), $sformatf("rnd a=%h rm=%0d", a, rm));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
